game_state_ctrl: RTL and testbench
==================================

# game_state_ctrl

Top-level game flow controller: owns the `game_active` state consumed by the start/restart button overlay and all gameplay blocks. Turns the overlay's one-cycle `game_start` pulse (or a start request from the partner board) into a frame-timed countdown, play phase and game-over phase. Its HP-based end-of-round detection drives the restart screen. Sits directly upstream of the start/restart overlay, sharing its clock domain (65 MHz pixel clock).

## Interface
Parameters:
- `FRAMES_PER_SEC`, 60: frame ticks per countdown second.
- `COUNTDOWN_SEC`, 3: countdown length in seconds, 1..7.
- `HOLDOFF_FRAMES`, 30: frames in OVER during which restart requests are ignored, 0..255.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: pixel clock.
- `rst`  in  1: synchronous active-high reset.
- `frame_tick`  in  1: one-cycle pulse per frame (vblank start).
- `game_start`  in  1: one-cycle local start/restart request from the overlay.
- `remote_start`  in  1: one-cycle start request decoded from the partner link.
- `player_hp`  in  7: local player HP.
- `boss_hp`  in  8: boss HP.
- `game_active`  out  2: 0 MENU, 1 PLAYING, 2 OVER, 3 COUNTDOWN.
- `countdown_sec`  out  3: seconds remaining, valid in COUNTDOWN, else 0.
- `round_reset`  out  1: one-cycle pulse to re-init player, boss and projectiles.
- `start_tx`  out  1: one-cycle pulse requesting the link to send a start message.
- `game_won`  out  1: 1 if the last round ended by boss defeat; held until the next round_reset.

## Operation
- All inputs are registered once before use.
- MENU:
  - registered `game_start` or `remote_start` -> COUNTDOWN.
  - Pulse `round_reset`.
  - Pulse `start_tx` only if the request was local.
- COUNTDOWN:
  - On entry, `countdown_sec` = COUNTDOWN_SEC and the frame sub-counter = 0.
  - Each registered `frame_tick` increments the sub-counter.
  - When the sub-counter reaches FRAMES_PER_SEC-1 and a tick arrives: sub-counter wraps to 0 and `countdown_sec` decrements.
  - When the decrement would take `countdown_sec` to 0 -> PLAYING.
  - Start requests are ignored.
- PLAYING:
  - registered `player_hp` == 0 -> OVER with `game_won` = 0.
  - Otherwise, registered `boss_hp` == 0 -> OVER with `game_won` = 1.
  - Both zero in the same cycle: loss wins (`game_won` = 0).
  - Start requests are ignored.
- OVER:
  - Holdoff counter loads HOLDOFF_FRAMES on entry and decrements per tick.
  - When it reaches 0, a start request -> COUNTDOWN with the same pulses as MENU.
  - `game_won` clears on that `round_reset`.
- Simultaneous local and remote start: a single transition; `start_tx` still pulses.
- Reset in any state:
  - -> MENU.
  - All outputs 0.
  - Counters 0.
  - No pulse emitted in the reset cycle or the cycle after.

## Timing
- `game_start` high in cycle N -> registered at edge N+1 -> state, `game_active`, `round_reset` and `start_tx` update at edge N+2.
  - Total latency: 2 cycles.
  - `round_reset` is high exactly in the first cycle `game_active` = 3.
- `frame_tick` in cycle T -> `countdown_sec` changes at edge T+2.
- Countdown length = COUNTDOWN_SEC*FRAMES_PER_SEC ticks after entry.
  - Entry with a tick in the same cycle: that tick is not counted.
- HP reaching 0 in cycle H -> `game_active` = 2 at edge H+2.
- HOLDOFF_FRAMES = 0: restart is accepted immediately after entering OVER.
- Counter widths: `$clog2` of the parameter value + 1; no wrap beyond terminal counts.

## Structure
- Shared `game_pkg`:
  - `typedef enum logic [1:0] game_state_t {GS_MENU=0, GS_PLAY=1, GS_OVER=2, GS_COUNTDOWN=3}`.
  - Default timing constants.
  - `game_active` is a direct cast of the state register.
- Sub-module `frame_timer`:
  - Loadable down-counter advanced by `frame_tick`.
  - Outputs `done` level and `wrap` pulse.
  - Instantiated twice: countdown sub-second counter, holdoff.
- Second-level counting lives in the top FSM.

## Test plan
- Reset mid-COUNTDOWN -> next cycle after reset release: `game_active` = 0, `countdown_sec` = 0, no pulses.
- MENU, `game_start` pulse at cycle 10 -> at cycle 12: `game_active` = 3, `round_reset` = 1 and `start_tx` = 1 for one cycle, `countdown_sec` = 3; after 180 ticks `game_active` = 1; seconds step 3 -> 2 -> 1 at ticks 60 and 120.
- MENU, `remote_start` only -> COUNTDOWN entered with `start_tx` = 0; `game_start` pulses during COUNTDOWN or PLAYING have no effect.
- PLAYING, `player_hp` = 0 and `boss_hp` = 0 in the same cycle -> `game_active` = 2 two cycles later, `game_won` = 0; with `boss_hp` = 0 only -> `game_won` = 1.
- OVER with HOLDOFF_FRAMES = 30, `game_start` after 10 ticks -> ignored; `game_start` after 30 ticks -> COUNTDOWN, `round_reset` pulse, `game_won` cleared.
- `frame_tick` coincident with COUNTDOWN entry -> total countdown still exactly 180 counted ticks.

Source files
------------

// File: rtl/game_state_ctrl_pkg.sv
// Shared game flow types and default frame timing.
package game_pkg;

  typedef enum logic [1:0] {
    GS_MENU      = 2'd0,
    GS_PLAY      = 2'd1,
    GS_OVER      = 2'd2,
    GS_COUNTDOWN = 2'd3
  } game_state_t;

  localparam int unsigned DEF_FRAMES_PER_SEC = 60;
  localparam int unsigned DEF_COUNTDOWN_SEC  = 3;
  localparam int unsigned DEF_HOLDOFF_FRAMES = 30;

endpackage

// File: rtl/game_state_ctrl_if.sv
// Request, HP and status bundle between the game flow controller and its neighbours.
interface game_state_ctrl_if;

  logic       frame_tick;
  logic       game_start;
  logic       remote_start;
  logic [6:0] player_hp;
  logic [7:0] boss_hp;
  logic [1:0] game_active;
  logic [2:0] countdown_sec;
  logic       round_reset;
  logic       start_tx;
  logic       game_won;

  modport master (
    output frame_tick, game_start, remote_start, player_hp, boss_hp,
    input  game_active, countdown_sec, round_reset, start_tx, game_won
  );

  modport slave (
    input  frame_tick, game_start, remote_start, player_hp, boss_hp,
    output game_active, countdown_sec, round_reset, start_tx, game_won
  );

endinterface

// File: rtl/game_state_ctrl_frame_timer.sv
// Loadable frame down-counter: done while at zero, wrap on a tick at zero.
// Latency: count moves one cycle after tick_i; wrap_o is combinational from tick_i.
// Backpressure: none; ticks arriving during load are dropped.
module frame_timer #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned LOAD_VAL = 0,
  parameter bit          RELOAD   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic tick_i,
  output logic done_o,
  output logic wrap_o
);

  localparam logic [WIDTH-1:0] LOAD_W = WIDTH'(LOAD_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Without RELOAD the counter parks at zero instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_W;
    end else if (tick_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - WIDTH'(1);
      end else if (RELOAD) begin
        cnt_d = LOAD_W;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);
  assign wrap_o = tick_i && done_o;

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow FSM: MENU -> COUNTDOWN -> PLAYING -> OVER, with round pulses to gameplay and link.
// Latency: 2 cycles from any input to state and pulse outputs (input register + state register).
// Backpressure: none; start requests outside MENU or an expired OVER holdoff are dropped.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
  parameter int unsigned COUNTDOWN_SEC  = DEF_COUNTDOWN_SEC,
  parameter int unsigned HOLDOFF_FRAMES = DEF_HOLDOFF_FRAMES
) (
  input logic              clk,
  input logic              rst,
  game_state_ctrl_if.slave bus
);

  localparam int unsigned SUB_W  = $clog2(FRAMES_PER_SEC) + 1;
  localparam int unsigned HOLD_W = $clog2(HOLDOFF_FRAMES) + 1;
  localparam logic [2:0]  SEC_INIT = 3'(COUNTDOWN_SEC);

  logic       tick_q, start_q, rstart_q;
  logic [6:0] php_q;
  logic [7:0] bhp_q;

  game_state_t state_q, state_d;
  logic [2:0]  sec_q, sec_d;
  logic        won_q, won_d;
  logic        rr_q, rr_d;
  logic        tx_q, tx_d;

  logic req;
  logic cd_load, cd_tick, cd_done, cd_wrap;
  logic hold_load, hold_tick, hold_done, hold_wrap;
  logic unused_timer_flags;

  assign req       = start_q | rstart_q;
  assign cd_load   = (state_q != GS_COUNTDOWN) && (state_d == GS_COUNTDOWN);
  assign hold_load = (state_q != GS_OVER) && (state_d == GS_OVER);
  assign cd_tick   = tick_q && (state_q == GS_COUNTDOWN);
  assign hold_tick = tick_q && (state_q == GS_OVER);

  // Sub-second counter reloads with FRAMES_PER_SEC-1, so a wrap marks one full second.
  frame_timer #(
    .WIDTH    (SUB_W),
    .LOAD_VAL (FRAMES_PER_SEC - 1),
    .RELOAD   (1'b1)
  ) u_sub_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (cd_load),
    .tick_i (cd_tick),
    .done_o (cd_done),
    .wrap_o (cd_wrap)
  );

  frame_timer #(
    .WIDTH    (HOLD_W),
    .LOAD_VAL (HOLDOFF_FRAMES),
    .RELOAD   (1'b0)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (hold_load),
    .tick_i (hold_tick),
    .done_o (hold_done),
    .wrap_o (hold_wrap)
  );

  assign unused_timer_flags = cd_done ^ hold_wrap;

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    won_d   = won_q;
    rr_d    = 1'b0;
    tx_d    = 1'b0;
    case (state_q)
      GS_MENU: begin
        if (req) state_d = GS_COUNTDOWN;
      end
      GS_COUNTDOWN: begin
        if (cd_wrap) begin
          if (sec_q <= 3'd1) begin
            state_d = GS_PLAY;
            sec_d   = '0;
          end else begin
            sec_d = sec_q - 3'd1;
          end
        end
      end
      GS_PLAY: begin
        // A simultaneous double KO counts as a loss.
        if (php_q == '0) begin
          state_d = GS_OVER;
          won_d   = 1'b0;
        end else if (bhp_q == '0) begin
          state_d = GS_OVER;
          won_d   = 1'b1;
        end
      end
      GS_OVER: begin
        if (req && hold_done) state_d = GS_COUNTDOWN;
      end
      default: ;
    endcase
    if (cd_load) begin
      rr_d  = 1'b1;
      tx_d  = start_q;
      sec_d = SEC_INIT;
      won_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q   <= 1'b0;
      start_q  <= 1'b0;
      rstart_q <= 1'b0;
      php_q    <= '0;
      bhp_q    <= '0;
      state_q  <= GS_MENU;
      sec_q    <= '0;
      won_q    <= 1'b0;
      rr_q     <= 1'b0;
      tx_q     <= 1'b0;
    end else begin
      tick_q   <= bus.frame_tick;
      start_q  <= bus.game_start;
      rstart_q <= bus.remote_start;
      php_q    <= bus.player_hp;
      bhp_q    <= bus.boss_hp;
      state_q  <= state_d;
      sec_q    <= sec_d;
      won_q    <= won_d;
      rr_q     <= rr_d;
      tx_q     <= tx_d;
    end
  end

  assign bus.game_active   = state_q;
  assign bus.countdown_sec = sec_q;
  assign bus.round_reset   = rr_q;
  assign bus.start_tx      = tx_q;
  assign bus.game_won      = won_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench: every expected state change is queued when its stimulus is driven.
module tb_game_state_ctrl;
  import game_pkg::*;

  localparam int TB_FPS  = 60;
  localparam int TB_SEC  = 3;
  localparam int TB_HOLD = 30;

  typedef struct {
    int         cyc;
    logic [1:0] act;
    logic       rr;
    logic       tx;
    logic [2:0] sec;
    logic       won;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;
  logic [1:0] prev_act = 2'd0;
  exp_t sb[$];

  game_state_ctrl_if bus ();

  game_state_ctrl #(
    .FRAMES_PER_SEC (TB_FPS),
    .COUNTDOWN_SEC  (TB_SEC),
    .HOLDOFF_FRAMES (TB_HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_evt(input int dc, input logic [1:0] act, input logic rr,
                            input logic tx, input logic [2:0] sec, input logic won);
    exp_t e;
    e.cyc = cyc + dc;
    e.act = act;
    e.rr  = rr;
    e.tx  = tx;
    e.sec = sec;
    e.won = won;
    sb.push_back(e);
  endtask

  // An event is any change of game_active or any round_reset pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.game_active != prev_act || bus.round_reset) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("evt_cycle", cyc, e.cyc);
          chk("evt_state", bus.game_active, e.act);
          chk("evt_round_reset", bus.round_reset, e.rr);
          chk("evt_start_tx", bus.start_tx, e.tx);
          chk("evt_sec", bus.countdown_sec, e.sec);
          chk("evt_won", bus.game_won, e.won);
        end
      end else if (bus.start_tx) begin
        chk("stray_start_tx", bus.start_tx, 0);
      end
    end
    prev_act <= bus.game_active;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic ls, input logic rs, input logic tk);
    bus.game_start   = ls;
    bus.remote_start = rs;
    bus.frame_tick   = tk;
    step(1);
    bus.game_start   = 1'b0;
    bus.remote_start = 1'b0;
    bus.frame_tick   = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      pulse(1'b0, 1'b0, 1'b1);
      step(1);
    end
  endtask

  // Drives exactly the countdown's worth of counted ticks; the last one must end it.
  task automatic run_cd();
    for (int k = 1; k <= TB_SEC * TB_FPS; k++) begin
      if (k == TB_SEC * TB_FPS) expect_evt(2, GS_PLAY, 1'b0, 1'b0, 3'd0, 1'b0);
      pulse(1'b0, 1'b0, 1'b1);
      step(1);
      if (k == TB_FPS - 1)     chk("sec_before_1st", bus.countdown_sec, 3);
      if (k == TB_FPS)         chk("sec_after_1st", bus.countdown_sec, 2);
      if (k == 2 * TB_FPS - 1) chk("sec_before_2nd", bus.countdown_sec, 2);
      if (k == 2 * TB_FPS)     chk("sec_after_2nd", bus.countdown_sec, 1);
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.frame_tick   = 1'b0;
    bus.game_start   = 1'b0;
    bus.remote_start = 1'b0;
    bus.player_hp    = 7'd50;
    bus.boss_hp      = 8'd100;
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_state", bus.game_active, GS_MENU);
    chk("rst_sec", bus.countdown_sec, 0);
    chk("rst_round_reset", bus.round_reset, 0);
    chk("rst_start_tx", bus.start_tx, 0);
    chk("rst_won", bus.game_won, 0);
    mon_en = 1'b1;
    step(5);

    // Local start from MENU, full countdown.
    expect_evt(2, GS_COUNTDOWN, 1'b1, 1'b1, 3'd3, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    run_cd();
    step(2);
    chk("play_state", bus.game_active, GS_PLAY);

    // Start requests during PLAYING are ignored.
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    step(4);
    chk("play_ignores_start", bus.game_active, GS_PLAY);

    // Boss defeat.
    expect_evt(2, GS_OVER, 1'b0, 1'b0, 3'd0, 1'b1);
    bus.boss_hp = 8'd0;
    step(3);
    chk("won_after_boss_ko", bus.game_won, 1);

    // Holdoff: a start after 10 and after 29 ticks is dropped.
    ticks(10);
    pulse(1'b1, 1'b0, 1'b0);
    step(4);
    chk("holdoff_10", bus.game_active, GS_OVER);
    ticks(19);
    pulse(1'b1, 1'b0, 1'b0);
    step(4);
    chk("holdoff_29", bus.game_active, GS_OVER);
    chk("won_held", bus.game_won, 1);
    ticks(1);
    bus.boss_hp = 8'd100;

    // Restart with a tick in the same cycle as the request: that tick is not counted.
    expect_evt(2, GS_COUNTDOWN, 1'b1, 1'b1, 3'd3, 1'b0);
    pulse(1'b1, 1'b0, 1'b1);
    run_cd();
    step(2);

    // Double KO in one cycle counts as a loss.
    expect_evt(2, GS_OVER, 1'b0, 1'b0, 3'd0, 1'b0);
    bus.player_hp = 7'd0;
    bus.boss_hp   = 8'd0;
    step(1);
    bus.player_hp = 7'd50;
    bus.boss_hp   = 8'd100;
    step(3);
    chk("over_after_double_ko", bus.game_active, GS_OVER);
    chk("won_after_double_ko", bus.game_won, 0);

    // Back to MENU via reset, then a remote-only start.
    expect_evt(1, GS_MENU, 1'b0, 1'b0, 3'd0, 1'b0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    expect_evt(2, GS_COUNTDOWN, 1'b1, 1'b0, 3'd3, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    ticks(65);
    chk("remote_cd_sec", bus.countdown_sec, 2);
    pulse(1'b1, 1'b0, 1'b0);
    step(3);
    chk("cd_ignores_start", bus.game_active, GS_COUNTDOWN);

    // Reset mid-countdown.
    expect_evt(1, GS_MENU, 1'b0, 1'b0, 3'd0, 1'b0);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst2_state", bus.game_active, GS_MENU);
    chk("rst2_sec", bus.countdown_sec, 0);
    chk("rst2_round_reset", bus.round_reset, 0);
    chk("rst2_start_tx", bus.start_tx, 0);

    // Local and remote together: one transition, start_tx still pulses.
    expect_evt(2, GS_COUNTDOWN, 1'b1, 1'b1, 3'd3, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    step(4);

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
